// File: rtl/ldtu_orbit_framer_if.sv
// Framer-side bundle: DTU pull port, orbit marker and serializer word port.
// master = framer, slave = the environment around it.
interface ldtu_orbit_framer_if #(
  parameter int Nbits_32 = 32,
  parameter int crcBits  = 12
);
  logic                Orbit;
  logic [Nbits_32-1:0] DATA32_in;
  logic                data_valid;
  logic                ser_ready;
  logic                handshake;
  logic [Nbits_32-1:0] DATA32_out;
  logic [crcBits-1:0]  frame_id;
  logic                crc_busy;

  modport master (
    input  Orbit, DATA32_in, data_valid, ser_ready,
    output handshake, DATA32_out, frame_id, crc_busy
  );
  modport slave (
    output Orbit, DATA32_in, data_valid, ser_ready,
    input  handshake, DATA32_out, frame_id, crc_busy
  );
endinterface

// File: rtl/ldtu_orbit_framer.sv
// Orbit framer: wraps DTU words into header / data-or-idle / trailer frames,
// with a word count and CRC-12 (poly 0x80F) carried in the trailer.
module ldtu_orbit_framer #(
  parameter int                 Nbits_32  = 32,
  parameter int                 crcBits   = 12,
  parameter logic [Nbits_32-1:0] IDLE_WORD = 32'hEAAAAAAA,
  parameter logic [7:0]         HDR_TAG   = 8'h5A,
  parameter logic [7:0]         TRL_TAG   = 8'hA5
) (
  input logic               CLK_A,
  input logic               RST_A,
  ldtu_orbit_framer_if.master bus
);

  typedef enum logic [1:0] {HEADER, DATA, TRAILER} state_t;

  localparam logic [crcBits-1:0] POLY = 12'h80F;

  state_t              state_q, state_d;
  logic [Nbits_32-1:0] out_q, out_d;
  logic [crcBits-1:0]  fid_q, fid_d;
  logic [crcBits-1:0]  cnt_q, cnt_d;
  logic [crcBits-1:0]  crc_q, crc_d;
  logic                pend_q, pend_d;
  logic                orbit_q, orbit_d;
  logic                orbit_edge;
  logic                pend_clr;
  logic                hs;

  // MSB-first, 32 bits folded into the CRC in one cycle.
  function automatic logic [crcBits-1:0] crc_step(input logic [crcBits-1:0] c,
                                                   input logic [Nbits_32-1:0] w);
    logic [crcBits-1:0] r;
    logic               fb;
    r = c;
    for (int i = Nbits_32 - 1; i >= 0; i--) begin
      fb = r[crcBits-1] ^ w[i];
      r  = (r << 1) ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  assign orbit_edge = bus.Orbit & ~orbit_q;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    fid_d    = fid_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    pend_clr = 1'b0;
    hs       = 1'b0;
    orbit_d  = bus.Orbit;
    if (bus.ser_ready) begin
      unique case (state_q)
        HEADER: begin
          out_d   = {HDR_TAG, 12'h000, fid_q};
          cnt_d   = '0;
          crc_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (pend_q) begin
            out_d    = {TRL_TAG, cnt_q, crc_q};
            pend_clr = 1'b1;
            state_d  = TRAILER;
          end else begin
            hs = 1'b1;
            if (bus.data_valid) begin
              out_d = bus.DATA32_in;
              cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
              crc_d = crc_step(crc_q, bus.DATA32_in);
            end else begin
              out_d = IDLE_WORD;
            end
          end
        end
        TRAILER: begin
          // Trailer stays on the output for this extra ready edge.
          fid_d   = fid_q + 1'b1;
          state_d = HEADER;
        end
        default: state_d = HEADER;
      endcase
    end
    // Edge and pending flag track every cycle so stalls cannot lose an orbit.
    pend_d = orbit_edge | (pend_q & ~pend_clr);
  end

  always_ff @(posedge CLK_A or negedge RST_A) begin
    if (!RST_A) begin
      state_q <= HEADER;
      out_q   <= IDLE_WORD;
      fid_q   <= '0;
      cnt_q   <= '0;
      crc_q   <= '0;
      pend_q  <= 1'b0;
      orbit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      fid_q   <= fid_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      pend_q  <= pend_d;
      orbit_q <= orbit_d;
    end
  end

  assign bus.handshake  = hs;
  assign bus.DATA32_out = out_q;
  assign bus.frame_id   = fid_q;
  assign bus.crc_busy   = (state_q == DATA);

endmodule

// File: tb/tb_ldtu_orbit_framer.sv
// Self-checking bench for ldtu_orbit_framer: directed scenarios plus random
// frames checked against a polynomial-division model of the trailer.
module tb_ldtu_orbit_framer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] frame_q[$];
  logic [11:0] exp_fid;
  logic [31:0] exp_out;

  ldtu_orbit_framer_if bus ();

  ldtu_orbit_framer dut (
    .CLK_A(clk),
    .RST_A(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC as remainder of M(x)*x^12 divided by x^12+x^11+x^3+x^2+x+1.
  function automatic logic [11:0] model_crc();
    logic [11:0] rem;
    logic [43:0] v;
    rem = '0;
    foreach (frame_q[k]) begin
      v = {rem, 32'h0} ^ {frame_q[k], 12'h0};
      for (int b = 43; b >= 12; b--)
        if (v[b]) v = v ^ (44'h180F << (b - 12));
      rem = v[11:0];
    end
    return rem;
  endfunction

  function automatic logic [31:0] model_trailer();
    int          n;
    logic [11:0] cnt;
    n   = frame_q.size();
    cnt = (n > 4095) ? 12'hFFF : n[11:0];
    return {8'hA5, cnt, model_crc()};
  endfunction

  // Pulse Orbit from DATA and walk through idle, trailer (twice), new header.
  task automatic do_orbit(input logic [31:0] exp_trl, input string name);
    bus.ser_ready  = 1'b1;
    bus.data_valid = 1'b0;
    bus.Orbit      = 1'b1;
    tick();
    n_checks++;
    if (bus.DATA32_out !== 32'hEAAAAAAA) begin
      n_fail++;
      $display("FAIL %s pre_trailer_idle: got %h want %h", name, bus.DATA32_out, 32'hEAAAAAAA);
    end
    bus.Orbit = 1'b0;
    #1;
    n_checks++;
    if (bus.handshake !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handshake_pending: got %b want 0", name, bus.handshake);
    end
    tick();
    n_checks++;
    if (bus.DATA32_out !== exp_trl || bus.crc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s trailer: got %h busy %b want %h busy 0", name, bus.DATA32_out, bus.crc_busy, exp_trl);
    end
    tick();
    exp_fid = exp_fid + 12'd1;
    n_checks++;
    if (bus.DATA32_out !== exp_trl || bus.frame_id !== exp_fid) begin
      n_fail++;
      $display("FAIL %s trailer_hold: got %h fid %h want %h fid %h", name, bus.DATA32_out, bus.frame_id, exp_trl, exp_fid);
    end
    tick();
    n_checks++;
    if (bus.DATA32_out !== {8'h5A, 12'h000, exp_fid}) begin
      n_fail++;
      $display("FAIL %s next_header: got %h want %h", name, bus.DATA32_out, {8'h5A, 12'h000, exp_fid});
    end
    frame_q.delete();
    exp_out = bus.DATA32_out;
  endtask

  // One DATA-state cycle; expectation derived from ready/valid alone.
  task automatic data_cycle(input logic rdy, input logic vld, input logic [31:0] w, input string name);
    bus.ser_ready  = rdy;
    bus.data_valid = vld;
    bus.DATA32_in  = w;
    #1;
    n_checks++;
    if (bus.handshake !== rdy) begin
      n_fail++;
      $display("FAIL %s handshake: got %b want %b", name, bus.handshake, rdy);
    end
    tick();
    if (rdy) begin
      if (vld) begin
        exp_out = w;
        frame_q.push_back(w);
      end else begin
        exp_out = 32'hEAAAAAAA;
      end
    end
    n_checks++;
    if (bus.DATA32_out !== exp_out) begin
      n_fail++;
      $display("FAIL %s data_out: got %h want %h", name, bus.DATA32_out, exp_out);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.Orbit      = 1'b0;
    bus.ser_ready  = 1'b1;
    bus.data_valid = 1'b0;
    bus.DATA32_in  = '0;
    tick();
    tick();
    n_checks++;
    if (bus.DATA32_out !== 32'hEAAAAAAA || bus.handshake !== 1'b0 ||
        bus.frame_id !== 12'h000 || bus.crc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: out %h hs %b fid %h busy %b want eaaaaaaa 0 000 0",
               bus.DATA32_out, bus.handshake, bus.frame_id, bus.crc_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_fid = 12'h000;
    n_checks++;
    if (bus.DATA32_out !== 32'h5A000000 || bus.crc_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_header: got %h busy %b want 5a000000 busy 1", bus.DATA32_out, bus.crc_busy);
    end
    exp_out = bus.DATA32_out;
    frame_q.delete();
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 3; i++) data_cycle(1'b1, 1'b1, 32'h0, "pass");
    do_orbit(32'hA5003000, "pass");
    n_checks++;
    if (exp_fid !== 12'h001) begin
      n_fail++;
      $display("FAIL pass_fid: got %h want 001", bus.frame_id);
    end
  endtask

  task automatic test_crc();
    data_cycle(1'b1, 1'b1, 32'h00000001, "crc");
    n_checks++;
    if (model_trailer() !== 32'hA500180F) begin
      n_fail++;
      $display("FAIL crc_model: got %h want a500180f", model_trailer());
    end
    do_orbit(32'hA500180F, "crc");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) data_cycle(1'b1, 1'b0, $urandom, "idle");
    do_orbit(32'hA5000000, "idle");
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = $urandom;
    data_cycle(1'b1, 1'b1, w, "stall_pre");
    for (int i = 0; i < 5; i++) begin
      bus.Orbit = (i == 1);
      data_cycle(1'b0, 1'b1, $urandom, "stall");
    end
    bus.Orbit      = 1'b0;
    bus.ser_ready  = 1'b1;
    bus.data_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.handshake !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_pending_hs: got %b want 0", bus.handshake);
    end
    tick();
    n_checks++;
    if (bus.DATA32_out !== model_trailer()) begin
      n_fail++;
      $display("FAIL stall_trailer: got %h want %h", bus.DATA32_out, model_trailer());
    end
    tick();
    tick();
    exp_fid = exp_fid + 12'd1;
    n_checks++;
    if (bus.DATA32_out !== {8'h5A, 12'h000, exp_fid}) begin
      n_fail++;
      $display("FAIL stall_header: got %h want %h", bus.DATA32_out, {8'h5A, 12'h000, exp_fid});
    end
    frame_q.delete();
    exp_out = bus.DATA32_out;
  endtask

  task automatic test_random_frames();
    int len;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(0, 24);
      for (int k = 0; k < len; k++)
        data_cycle(($urandom % 4) != 0, ($urandom % 3) != 0, $urandom, "rand");
      do_orbit(model_trailer(), "rand");
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 4100; k++) begin
      bus.ser_ready  = 1'b1;
      bus.data_valid = 1'b1;
      bus.DATA32_in  = $urandom;
      frame_q.push_back(bus.DATA32_in);
      tick();
    end
    n_checks++;
    if (bus.DATA32_out !== frame_q[frame_q.size()-1]) begin
      n_fail++;
      $display("FAIL sat_last_word: got %h want %h", bus.DATA32_out, frame_q[frame_q.size()-1]);
    end
    do_orbit(model_trailer(), "sat");
  endtask

  task automatic test_reset_mid();
    data_cycle(1'b1, 1'b1, $urandom, "rmid");
    data_cycle(1'b1, 1'b1, $urandom, "rmid");
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.DATA32_out !== 32'hEAAAAAAA || bus.frame_id !== 12'h000 ||
        bus.crc_busy !== 1'b0 || bus.handshake !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out %h fid %h busy %b hs %b want eaaaaaaa 000 0 0",
               bus.DATA32_out, bus.frame_id, bus.crc_busy, bus.handshake);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_fid = 12'h000;
    n_checks++;
    if (bus.DATA32_out !== 32'h5A000000) begin
      n_fail++;
      $display("FAIL reset_mid_header: got %h want 5a000000", bus.DATA32_out);
    end
    frame_q.delete();
    exp_out = bus.DATA32_out;
  endtask

  task automatic test_wrap();
    bus.ser_ready  = 1'b1;
    bus.data_valid = 1'b0;
    for (int i = 0; i < 4095; i++) begin
      bus.Orbit = 1'b1;
      tick();
      bus.Orbit = 1'b0;
      tick();
      tick();
      tick();
    end
    exp_fid = 12'hFFF;
    n_checks++;
    if (bus.frame_id !== 12'hFFF || bus.DATA32_out !== 32'h5A000FFF) begin
      n_fail++;
      $display("FAIL wrap_top: fid %h out %h want fff 5a000fff", bus.frame_id, bus.DATA32_out);
    end
    exp_out = bus.DATA32_out;
    do_orbit(32'hA5000000, "wrap");
    n_checks++;
    if (bus.frame_id !== 12'h000) begin
      n_fail++;
      $display("FAIL wrap_zero: got %h want 000", bus.frame_id);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_passthrough();
    test_crc();
    test_idle();
    test_stall();
    test_random_frames();
    test_saturate();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
